br_rs: RTL
==========

BR_RS -- requirements
Module: br_rs

Interface
REQ-001 Parameter RS_NUM, default 4: number of branch reservation-station entries.
REQ-002 Parameter PRF_IDX_W, default 6: physical-register tag width.
REQ-003 Parameter ROB_IDX_W, default 5: ROB index width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 dispatch_en_i  in  1  dispatch a branch this cycle.
REQ-008 dispatch_npc_i  in  64  PC+4 of dispatched branch.
REQ-009 dispatch_inst_i  in  32  branch instruction word.
REQ-010 dispatch_opa_tag_i  in  PRF_IDX_W  physical tag of regA.
REQ-011 dispatch_opa_rdy_i  in  1  regA value valid at dispatch.
REQ-012 dispatch_opa_i  in  64  regA value, meaningful when dispatch_opa_rdy_i=1.
REQ-013 dispatch_rob_idx_i  in  ROB_IDX_W  ROB entry of branch.
REQ-014 cdb_valid_i  in  1  CDB broadcast valid.
REQ-015 cdb_tag_i  in  PRF_IDX_W  broadcast tag.
REQ-016 cdb_value_i  in  64  broadcast value.
REQ-017 flush_i  in  1  mispredict squash: kill all entries.
REQ-018 full_o  out  1  no free entry; dispatch must stall.
REQ-019 start_o  out  1  issue valid to branch ALU.
REQ-020 npc_o  out  64, opa_o  out  64, inst_o  out  32, rob_idx_o  out  ROB_IDX_W  issued branch fields.

Function
REQ-021 Each entry SHALL hold valid, npc, inst, rob_idx, opa_tag, opa_rdy, opa value, and an age rank.
REQ-022 Dispatch with dispatch_en_i=1 and full_o=0 SHALL write the lowest-index free entry; dispatch while full_o=1 SHALL be ignored.
REQ-023 full_o SHALL be 1 iff all RS_NUM entries are valid at the start of the cycle; an entry freed by issue in the same cycle SHALL NOT clear full_o that cycle.
REQ-024 Wakeup: cdb_valid_i=1 with cdb_tag_i equal to a valid, not-ready entry's opa_tag SHALL set opa_rdy and capture cdb_value_i at the clock edge.
REQ-025 Dispatch-cycle bypass: if dispatch_opa_rdy_i=0 and a CDB broadcast in the same cycle matches dispatch_opa_tag_i, the entry SHALL be written ready with cdb_value_i.
REQ-026 An entry is eligible for issue only if valid and opa_rdy at the start of the cycle; an entry written or woken this cycle SHALL NOT issue before the next cycle.
REQ-027 At most one entry SHALL issue per cycle: the eligible entry with the oldest dispatch order.
REQ-028 Issue SHALL register the entry's fields to npc_o/opa_o/inst_o/rob_idx_o and set start_o=1 on the next edge (1-cycle latency); the entry SHALL be freed at that edge.
REQ-029 start_o SHALL be 0 in any cycle following a cycle with no eligible entry; data outputs hold last value.
REQ-030 The downstream ALU always accepts; no back-pressure path exists.
REQ-031 Age ranks SHALL stay a strict total order over valid entries across arbitrary dispatch/issue interleavings (no wrap ambiguity).
REQ-032 flush_i=1 SHALL clear all valid bits and force start_o=0 at the next edge; dispatch, wakeup and issue in the flush cycle SHALL be discarded.
REQ-033 Simultaneous dispatch and issue into a non-full RS SHALL both take effect.

Reset
REQ-034 rst=1 SHALL clear all entry valid bits and set start_o, npc_o, opa_o, inst_o, rob_idx_o to 0 at the next edge; full_o=0 thereafter.
REQ-035 rst SHALL take priority over flush_i, dispatch and CDB inputs; reset mid-operation discards all entries.

Verification
REQ-036 Dispatch rdy entry (npc=0x1004, opa=0, rob=3) into empty RS -> start_o=1 two edges after dispatch edge with npc_o=0x1004, rob_idx_o=3.
REQ-037 Dispatch not-ready tag 12, then CDB tag 12 value 0x55 -> next cycle eligible; issue with opa_o=0x55.
REQ-038 Dispatch with tag 7 not ready while CDB broadcasts tag 7 value 0x9 same cycle -> entry issues with opa_o=0x9 without further broadcast.
REQ-039 Fill 4 entries not ready (rob 1,2,3,4), wake all same cycle -> issue order rob 1,2,3,4 on consecutive cycles; full_o=1 until first issue edge, 5th dispatch in full cycle dropped.
REQ-040 3 valid entries, flush_i=1 with simultaneous dispatch -> next cycle no valid entries, start_o=0, full_o=0, dispatched branch never issues.
REQ-041 rst asserted with 2 ready entries -> start_o=0 and all outputs 0 next edge; no later issue of those entries.

Source files
------------

// File: rtl/br_rs.sv
// Branch reservation station: holds dispatched branches until regA is ready,
// then issues the oldest ready entry to the branch ALU with one-cycle latency.
module br_rs #(
    parameter int unsigned RS_NUM    = 4,
    parameter int unsigned PRF_IDX_W = 6,
    parameter int unsigned ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dispatch_en_i,
    input  logic [63:0]          dispatch_npc_i,
    input  logic [31:0]          dispatch_inst_i,
    input  logic [PRF_IDX_W-1:0] dispatch_opa_tag_i,
    input  logic                 dispatch_opa_rdy_i,
    input  logic [63:0]          dispatch_opa_i,
    input  logic [ROB_IDX_W-1:0] dispatch_rob_idx_i,
    input  logic                 cdb_valid_i,
    input  logic [PRF_IDX_W-1:0] cdb_tag_i,
    input  logic [63:0]          cdb_value_i,
    input  logic                 flush_i,
    output logic                 full_o,
    output logic                 start_o,
    output logic [63:0]          npc_o,
    output logic [63:0]          opa_o,
    output logic [31:0]          inst_o,
    output logic [ROB_IDX_W-1:0] rob_idx_o
);

    localparam int unsigned RANK_W = (RS_NUM > 1) ? $clog2(RS_NUM) : 1;
    localparam int unsigned CNT_W  = $clog2(RS_NUM + 1);

    logic                 r_valid [RS_NUM];
    logic                 r_rdy   [RS_NUM];
    logic [63:0]          r_npc   [RS_NUM];
    logic [31:0]          r_inst  [RS_NUM];
    logic [ROB_IDX_W-1:0] r_rob   [RS_NUM];
    logic [PRF_IDX_W-1:0] r_tag   [RS_NUM];
    logic [63:0]          r_opa   [RS_NUM];
    logic [RANK_W-1:0]    r_rank  [RS_NUM];
    logic                 r_full;

    logic                 w_issue_vld;
    logic [RANK_W-1:0]    w_issue_idx;
    logic [RANK_W-1:0]    w_issue_rank;
    logic                 w_free_vld;
    logic [RANK_W-1:0]    w_free_idx;
    logic                 w_disp_fire;
    logic [CNT_W-1:0]     w_cnt;
    logic [RANK_W-1:0]    w_new_rank;
    logic                 w_byp;
    logic                 w_full_nxt;

    // Oldest ready entry: rank 0 is the oldest valid entry.
    always_comb begin
        w_issue_vld  = 1'b0;
        w_issue_idx  = '0;
        w_issue_rank = '0;
        for (int i = 0; i < RS_NUM; i++) begin
            if (r_valid[i] && r_rdy[i] && (!w_issue_vld || (r_rank[i] < w_issue_rank))) begin
                w_issue_vld  = 1'b1;
                w_issue_idx  = RANK_W'(i);
                w_issue_rank = r_rank[i];
            end
        end
    end

    // Lowest free slot, valid count and next-cycle occupancy.
    always_comb begin
        w_free_vld = 1'b0;
        w_free_idx = '0;
        w_cnt      = '0;
        for (int i = 0; i < RS_NUM; i++) begin
            w_cnt = w_cnt + CNT_W'(r_valid[i]);
            if (!r_valid[i] && !w_free_vld) begin
                w_free_vld = 1'b1;
                w_free_idx = RANK_W'(i);
            end
        end
        w_disp_fire = dispatch_en_i && !r_full && w_free_vld;
        w_new_rank  = RANK_W'(w_cnt - CNT_W'(w_issue_vld));
        w_byp       = cdb_valid_i && (cdb_tag_i == dispatch_opa_tag_i);
        w_full_nxt  = 1'b1;
        for (int i = 0; i < RS_NUM; i++) begin
            if (!((r_valid[i] && !(w_issue_vld && (w_issue_idx == RANK_W'(i)))) ||
                  (w_disp_fire && (w_free_idx == RANK_W'(i))))) begin
                w_full_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_NUM; i++) begin
                r_valid[i] <= 1'b0;
            end
            r_full    <= 1'b0;
            start_o   <= 1'b0;
            npc_o     <= '0;
            opa_o     <= '0;
            inst_o    <= '0;
            rob_idx_o <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < RS_NUM; i++) begin
                r_valid[i] <= 1'b0;
            end
            r_full  <= 1'b0;
            start_o <= 1'b0;
        end else begin
            r_full  <= w_full_nxt;
            start_o <= w_issue_vld;
            if (w_issue_vld) begin
                npc_o     <= r_npc[w_issue_idx];
                opa_o     <= r_opa[w_issue_idx];
                inst_o    <= r_inst[w_issue_idx];
                rob_idx_o <= r_rob[w_issue_idx];
            end
            for (int i = 0; i < RS_NUM; i++) begin
                if (w_issue_vld && (w_issue_idx == RANK_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end else if (r_valid[i] && !r_rdy[i] && cdb_valid_i && (cdb_tag_i == r_tag[i])) begin
                    r_rdy[i] <= 1'b1;
                    r_opa[i] <= cdb_value_i;
                end
                // Close the gap left by the issued entry so ranks stay contiguous.
                if (w_issue_vld && r_valid[i] && (r_rank[i] > w_issue_rank)) begin
                    r_rank[i] <= r_rank[i] - RANK_W'(1);
                end
                if (w_disp_fire && (w_free_idx == RANK_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_npc[i]   <= dispatch_npc_i;
                    r_inst[i]  <= dispatch_inst_i;
                    r_rob[i]   <= dispatch_rob_idx_i;
                    r_tag[i]   <= dispatch_opa_tag_i;
                    r_rdy[i]   <= dispatch_opa_rdy_i || w_byp;
                    r_opa[i]   <= dispatch_opa_rdy_i ? dispatch_opa_i : cdb_value_i;
                    r_rank[i]  <= w_new_rank;
                end
            end
        end
    end

    assign full_o = r_full;

endmodule
